lsu_mem_ctrl: RTL and testbench

Load/store memory controller for the MEM stage. Accepts one load or store per transaction from the EX/MEM boundary, checks alignment, generates a word-aligned data-memory request with byte enables and lane-replicated store data, and waits for the variable-latency grant and response handshake. On a load, it registers the raw 32-bit word and its address bits and hands them to the downstream load extraction block.

---
 rtl/lsu_pkg.sv | 66 ++++++
 rtl/lsu_mem_ctrl_store_align.sv | 36 +++
 rtl/lsu_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store controller: access size
// encodings, FSM states, byte-enable base patterns, response payload and the
// legality check applied at op acceptance.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned SIZE_W = 3;

    // Load sizes
    localparam logic [SIZE_W-1:0] LD_LB  = 3'b000;
    localparam logic [SIZE_W-1:0] LD_LH  = 3'b001;
    localparam logic [SIZE_W-1:0] LD_LW  = 3'b010;
    localparam logic [SIZE_W-1:0] LD_LBU = 3'b011;
    localparam logic [SIZE_W-1:0] LD_LHU = 3'b100;

    // Store sizes
    localparam logic [SIZE_W-1:0] ST_SB  = 3'b000;
    localparam logic [SIZE_W-1:0] ST_SH  = 3'b001;
    localparam logic [SIZE_W-1:0] ST_SW  = 3'b010;

    // Byte-enable base patterns, shifted into lane position for sub-word stores
    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Completion payload handed to the load extraction block
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [1:0]        addr_lo;
        logic [SIZE_W-1:0] load_type;
        logic              misalign;
    } rsp_t;

    // Misaligned halfword/word access or unsupported size encoding
    function automatic logic op_illegal(input logic              is_store,
                                        input logic [SIZE_W-1:0] size,
                                        input logic [1:0]        addr_lo);
        logic bad;
        bad = 1'b0;
        if (is_store) begin
            case (size)
                ST_SB:   bad = 1'b0;
                ST_SH:   bad = addr_lo[0];
                ST_SW:   bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end else begin
            case (size)
                LD_LB, LD_LBU: bad = 1'b0;
                LD_LH, LD_LHU: bad = addr_lo[0];
                LD_LW:         bad = |addr_lo;
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_store_align.sv
// store_align: combinational lane placement for the memory request.
//   is_store, size, addr_lo, wdata -> be_c (byte enables), wdata_c (replicated data)
// Loads always request the full word; their write data is zero.
module store_align
    import lsu_pkg::*;
(
    input  logic              is_store,
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c
);

    always_comb begin
        be_c    = BE_WORD;
        wdata_c = '0;
        if (is_store) begin
            case (size)
                ST_SB: begin
                    be_c    = BE_BYTE << addr_lo;
                    wdata_c = {4{wdata[7:0]}};
                end
                ST_SH: begin
                    be_c    = BE_HALF << {addr_lo[1], 1'b0};
                    wdata_c = {2{wdata[15:0]}};
                end
                default: begin
                    be_c    = BE_WORD;
                    wdata_c = wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller.
//   req_*  : one op from EX/MEM, accepted when req_ready (IDLE)
//   mem_*  : word-aligned data-memory request, held stable until mem_gnt;
//            load data returns on mem_rvalid
//   rsp_*  : one-cycle completion pulse with raw word, address low bits,
//            load type and misalign/illegal flag
//   busy   : stall request to the pipeline, the inverse of req_ready
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_addr_lo,
    output logic [2:0]        rsp_load_type,
    output logic              rsp_misalign,
    output logic              busy
);

    state_e            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_t              rsp_q,       rsp_d;

    logic [BE_W-1:0]   align_be_c;
    logic [DATA_W-1:0] align_wdata_c;
    logic              illegal_c;

    // Lane placement on the capture path so it registers with the request
    store_align u_store_align (
        .is_store (req_is_store),
        .size     (req_size),
        .addr_lo  (req_addr[1:0]),
        .wdata    (req_wdata),
        .be_c     (align_be_c),
        .wdata_c  (align_wdata_c)
    );

    assign illegal_c = op_illegal(req_is_store, req_size, req_addr[1:0]);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_d        = rsp_q;
        // misalign only qualifies the completion pulse
        rsp_d.misalign = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rsp_d.addr_lo   = req_addr[1:0];
                    rsp_d.load_type = req_size;
                    if (illegal_c) begin
                        state_d        = S_RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_d.misalign = 1'b1;
                        rsp_d.rdata    = '0;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = align_be_c;
                        mem_wdata_d = align_wdata_c;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d.rdata = '0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_d.rdata = mem_rdata;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_q.rdata;
    assign rsp_addr_lo   = rsp_q.addr_lo;
    assign rsp_load_type = rsp_q.load_type;
    assign rsp_misalign  = rsp_q.misalign;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads, sub-word stores, illegal ops,
// grant/rvalid stalls, stray rvalid and mid-operation reset.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_addr_lo;
    logic [2:0]  rsp_load_type;
    logic        rsp_misalign;
    logic        busy;

    int n_cmp;
    int n_err;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_size      (req_size),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_addr_lo   (rsp_addr_lo),
        .rsp_load_type (rsp_load_type),
        .rsp_misalign  (rsp_misalign),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic st, input logic [2:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Store with gnt in cycle 1; checks request fields and completion in cycle 2
    task automatic do_store(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        present(1'b1, sz, addr, wd);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk({tag, "_req"},   32'(mem_req), 32'd1);
        chk({tag, "_we"},    32'(mem_we), 32'd1);
        chk({tag, "_addr"},  mem_addr, exp_addr);
        chk({tag, "_be"},    32'(mem_be), 32'(exp_be));
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_mis"},   32'(rsp_misalign), 32'd0);
        chk({tag, "_req0"},  32'(mem_req), 32'd0);
        tick();
        chk({tag, "_rspv0"}, 32'(rsp_valid), 32'd0);
    endtask

    // Illegal op: completes in cycle 1 with misalign, never requests memory
    task automatic do_bad(input string tag, input logic st, input logic [2:0] sz,
                          input logic [31:0] addr);
        present(st, sz, addr, 32'hFFFF_FFFF);
        tick();
        req_valid = 1'b0;
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd1);
        chk({tag, "_mis"},   32'(rsp_misalign), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_req"},   32'(mem_req), 32'd0);
        tick();
        chk({tag, "_rspv0"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req0"},  32'(mem_req), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_size     = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;

        // Reset values
        #3;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_rspv",  32'(rsp_valid), 32'd0);
        chk("rst_be",    32'(mem_be), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        #14 rst_n = 1'b1;
        tick();

        // LW 0x1000: req cycle 1, gnt cycle 1, rvalid cycle 2, rsp cycle 3
        present(1'b0, 3'b010, 32'h0000_1000, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("lw_req",  32'(mem_req), 32'd1);
        chk("lw_we",   32'(mem_we), 32'd0);
        chk("lw_addr", mem_addr, 32'h0000_1000);
        chk("lw_be",   32'(mem_be), 32'hF);
        chk("lw_busy", 32'(busy), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("lw_req0", 32'(mem_req), 32'd0);
        chk("lw_rspv_c2", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        chk("lw_rspv",  32'(rsp_valid), 32'd1);
        chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw_alo",   32'(rsp_addr_lo), 32'd0);
        chk("lw_type",  32'(rsp_load_type), 32'd2);
        chk("lw_mis",   32'(rsp_misalign), 32'd0);
        tick();
        chk("lw_rspv0", 32'(rsp_valid), 32'd0);
        chk("lw_ready", 32'(req_ready), 32'd1);

        // Sub-word stores
        do_store("sb", 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh", 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 4'b1100, 32'h1234_1234);
        do_store("sb1", 3'b000, 32'h0000_2001, 32'hFFFF_FF3C, 32'h0000_2000, 4'b0010, 32'h3C3C_3C3C);

        // Illegal ops
        do_bad("lh_mis",  1'b0, 3'b001, 32'h0000_3001);
        chk("lh_mis_alo",  32'(rsp_addr_lo), 32'd1);
        chk("lh_mis_type", 32'(rsp_load_type), 32'd1);
        do_bad("sw_mis",  1'b1, 3'b010, 32'h0000_3002);
        do_bad("ld_sz7",  1'b0, 3'b111, 32'h0000_3000);
        do_bad("st_sz3",  1'b1, 3'b011, 32'h0000_3000);

        // LHU at 0x4006 with 3 gnt stall cycles, same-cycle rvalid ignored, 2 rvalid stall cycles
        present(1'b0, 3'b100, 32'h0000_4006, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stl_req",  32'(mem_req), 32'd1);
            chk("stl_addr", mem_addr, 32'h0000_4004);
            chk("stl_be",   32'(mem_be), 32'hF);
            chk("stl_we",   32'(mem_we), 32'd0);
            chk("stl_busy", 32'(busy), 32'd1);
            chk("stl_rspv", 32'(rsp_valid), 32'd0);
            if (i == 3) begin
                mem_gnt    = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h1111_1111;
            end
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stw_req",  32'(mem_req), 32'd0);
            chk("stw_busy", 32'(busy), 32'd1);
            chk("stw_rspv", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("stw_rspv2", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("stl_rsp",   32'(rsp_valid), 32'd1);
        chk("stl_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("stl_alo",   32'(rsp_addr_lo), 32'd2);
        chk("stl_type",  32'(rsp_load_type), 32'd4);
        tick();
        chk("stl_once",  32'(rsp_valid), 32'd0);
        tick();
        chk("stl_once2", 32'(rsp_valid), 32'd0);

        // Stray rvalid while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        tick();
        chk("stray_rspv", 32'(rsp_valid), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rspv2", 32'(rsp_valid), 32'd0);
        chk("stray_ready", 32'(req_ready), 32'd1);

        // Reset during REQ: mem_req drops asynchronously
        present(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rreq_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rreq_req0",  32'(mem_req), 32'd0);
        chk("rreq_ready", 32'(req_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();

        // Reset during WAIT, then a late rvalid
        present(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rwait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rwait_req",   32'(mem_req), 32'd0);
        chk("rwait_ready", 32'(req_ready), 32'd1);
        chk("rwait_busy0", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("rwait_rspv", 32'(rsp_valid), 32'd0);
        tick();
        chk("rwait_rspv2", 32'(rsp_valid), 32'd0);

        // Reset during RESP: rsp_valid drops asynchronously
        present(1'b0, 3'b001, 32'h0000_6001, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rresp_rspv", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rresp_rspv0", 32'(rsp_valid), 32'd0);
        chk("rresp_mis0",  32'(rsp_misalign), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Word store after recovery
        do_store("sw", 3'b010, 32'h0000_7008, 32'hCAFE_F00D, 32'h0000_7008, 4'b1111, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
